instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Instruction fetch stage directly upstream of the main decoder.
- Holds the PC and issues word fetches to the instruction cache, tolerating miss stalls.
- Latches the returned word into an instruction register that feeds the decoder's opcode field and the rest of decode.
- Accepts branch/jump redirects from later stages and flushes the in-flight or held instruction.

Parameters:
ADDR_WIDTH, 32, width of PC and cache address
RESET_PC, 32'h0000_0000, first fetch address after reset
NOP_WORD, 32'h0000_0000, value driven on instr while no valid instruction is held

Ports:
clk  input  1  single clock, all state on rising edge
rst  input  1  synchronous active-high reset
icache_req  output  1  fetch request to instruction cache
icache_addr  output  ADDR_WIDTH  fetch byte address, word aligned
icache_rdata  input  32  fetched word, valid when icache_ready=1
icache_ready  input  1  one-cycle response strobe, only while icache_req=1
instr  output  32  held instruction to decoder
instr_pc  output  ADDR_WIDTH  address of held instruction
pc_plus4  output  ADDR_WIDTH  instr_pc+4 for branch/JAL use
instr_valid  output  1  instr holds a live instruction
instr_ready  input  1  decode accepts instr this cycle (low = hazard stall)
redirect  input  1  one-cycle branch-taken/jump pulse
redirect_pc  input  ADDR_WIDTH  redirect target
misalign_err  output  1  present only with MISALIGN_CHECK_EN

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high. Everything below happens on the rising edge of clk.
- Registers: pc (next fetch address), req_addr (drives icache_addr), instr, instr_pc, pc_plus4, instr_valid, state.
- Reset values:
  - state=IDLE, pc=RESET_PC, req_addr=RESET_PC.
  - instr=NOP_WORD, instr_pc=0, pc_plus4=0.
  - instr_valid=0, icache_req=0, misalign_err=0.
- States:
  - IDLE: icache_req=0. Next state FETCH, req_addr<=pc.
  - FETCH: icache_req=1; icache_addr=req_addr, held stable until icache_ready.
    - On icache_ready: instr<=icache_rdata, instr_pc<=req_addr, pc_plus4<=req_addr+4, pc<=req_addr+4, instr_valid<=1, next VALID.
  - VALID: icache_req=0, instr_valid=1, outputs held.
    - On instr_ready: instr_valid<=0, instr<=NOP_WORD, req_addr<=pc, next FETCH.
  - DRAIN: icache_req=1 with the old req_addr held stable. Returned data is discarded.
    - On icache_ready: req_addr<=pc, next FETCH.
- Throughput: best case one instruction per 2 cycles on cache hits. Cache latency is unbounded; instr_valid stays 0 while waiting.
- Redirect (priority over instr_ready and icache_ready):
  - All cases: pc<=redirect_pc, instr_valid<=0, instr<=NOP_WORD.
  - IDLE/VALID: req_addr<=redirect_pc, next FETCH.
  - FETCH with icache_ready=0: next DRAIN. An outstanding request is never abandoned.
  - FETCH with icache_ready=1: data discarded, req_addr<=redirect_pc, next FETCH.
  - DRAIN: pc overwritten (latest redirect wins), stay DRAIN unless icache_ready. If icache_ready, next FETCH at redirect_pc.
- Arithmetic: pc+4 wraps modulo 2^ADDR_WIDTH with no error. icache_addr[1:0] is always 00.
- Reset mid-operation: returns to reset values immediately, outstanding request abandoned (cache shares rst).
- instr_ready while instr_valid=0 is ignored.

Optional Feature:
- MISALIGN_CHECK_EN defined:
  - redirect with redirect_pc[1:0]!=00 goes to state ERROR.
  - ERROR: misalign_err=1 sticky, icache_req=0, instr_valid=0. Exit only by rst.
  - If a request is outstanding, DRAIN completes first, then ERROR.
- Not defined: no misalign_err port; redirect_pc[1:0] is forced to 00.

Test Plan:
- Reset release, RESET_PC=0x00400000, rst high 2 cycles -> cycle after release IDLE, icache_req=0. Next cycle icache_req=1, icache_addr=0x00400000.
- Hit: icache_ready=1 with rdata 0x8C080004 in the first FETCH cycle -> next cycle instr=0x8C080004, instr_pc=0x00400000, pc_plus4=0x00400004, instr_valid=1. With instr_ready=1, the following cycle icache_addr=0x00400004.
- Miss: icache_ready delayed 5 cycles -> icache_req=1 and icache_addr constant all 6 cycles, instr_valid=0 throughout, then captured.
- Decode stall: instr_ready=0 for 3 cycles in VALID -> instr, instr_pc and instr_valid=1 unchanged, icache_req=0. Release -> fetch of pc_plus4.
- Redirect during miss to 0x00400020 -> DRAIN, old address held until ready, data not presented (instr_valid stays 0). Next request at 0x00400020.
- Redirect coincident with instr_ready in VALID -> instr_valid=0 next cycle, next fetch at target. With MISALIGN_CHECK_EN, target 0x00400022 -> misalign_err=1, no further requests until rst.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, icache request handshake and the instruction register that feeds decode.
// Optional build macro MISALIGN_CHECK_EN traps misaligned redirect targets into a sticky ERROR state.
module instr_fetch_unit #(
   parameter int                    ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
   parameter logic [31:0]           NOP_WORD   = 32'h0000_0000
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  icache_req,
   output logic [ADDR_WIDTH-1:0] icache_addr,
   input  logic [31:0]           icache_rdata,
   input  logic                  icache_ready,
   output logic [31:0]           instr,
   output logic [ADDR_WIDTH-1:0] instr_pc,
   output logic [ADDR_WIDTH-1:0] pc_plus4,
   output logic                  instr_valid,
   input  logic                  instr_ready,
   input  logic                  redirect,
   input  logic [ADDR_WIDTH-1:0] redirect_pc
`ifdef MISALIGN_CHECK_EN
   ,
   output logic                  misalign_err
`endif
);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      VALID,
      DRAIN,
      ERROR
   } state_e;

   localparam logic [ADDR_WIDTH-1:0] FOUR       = ADDR_WIDTH'(4);
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
   logic [ADDR_WIDTH-1:0]   reqAddr_q, reqAddr_d;
   logic [31:0]             instr_q, instr_d;
   logic [ADDR_WIDTH-1:0]   instrPc_q, instrPc_d;
   logic [ADDR_WIDTH-1:0]   pcPlus4_q, pcPlus4_d;
   logic                    valid_q, valid_d;
   logic                    errPend_q, errPend_d;
   logic [ADDR_WIDTH-1:0]   target;
   logic                    misaligned;

`ifdef MISALIGN_CHECK_EN
   assign target     = redirect_pc;
   assign misaligned = |redirect_pc[1:0];
`else
   assign target     = redirect_pc & ALIGN_MASK;
   assign misaligned = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         pc_q      <= RESET_PC;
         reqAddr_q <= RESET_PC;
         instr_q   <= NOP_WORD;
         instrPc_q <= '0;
         pcPlus4_q <= '0;
         valid_q   <= 1'b0;
         errPend_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         reqAddr_q <= reqAddr_d;
         instr_q   <= instr_d;
         instrPc_q <= instrPc_d;
         pcPlus4_q <= pcPlus4_d;
         valid_q   <= valid_d;
         errPend_q <= errPend_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      reqAddr_d = reqAddr_q;
      instr_d   = instr_q;
      instrPc_d = instrPc_q;
      pcPlus4_d = pcPlus4_q;
      valid_d   = valid_q;
      errPend_d = errPend_q;

      // A redirect always kills the held instruction and retargets the PC
      if (redirect && state_q != ERROR) begin
         pc_d    = target;
         valid_d = 1'b0;
         instr_d = NOP_WORD;
      end

      case (state_q)
         IDLE: begin
            if (redirect && misaligned) begin
               state_d = ERROR;
            end else begin
               reqAddr_d = redirect ? target : pc_q;
               state_d   = FETCH;
            end
         end
         FETCH: begin
            if (redirect) begin
               if (!icache_ready) begin
                  // The cache still owes a response; absorb it before refetching
                  errPend_d = misaligned;
                  state_d   = DRAIN;
               end else if (misaligned) begin
                  state_d = ERROR;
               end else begin
                  reqAddr_d = target;
               end
            end else if (icache_ready) begin
               instr_d   = icache_rdata;
               instrPc_d = reqAddr_q;
               pcPlus4_d = reqAddr_q + FOUR;
               pc_d      = reqAddr_q + FOUR;
               valid_d   = 1'b1;
               state_d   = VALID;
            end
         end
         VALID: begin
            if (redirect) begin
               if (misaligned) begin
                  state_d = ERROR;
               end else begin
                  reqAddr_d = target;
                  state_d   = FETCH;
               end
            end else if (instr_ready) begin
               valid_d   = 1'b0;
               instr_d   = NOP_WORD;
               reqAddr_d = pc_q;
               state_d   = FETCH;
            end
         end
         DRAIN: begin
            if (redirect) begin
               errPend_d = misaligned;
            end
            if (icache_ready) begin
               errPend_d = 1'b0;
               if (redirect ? misaligned : errPend_q) begin
                  state_d = ERROR;
               end else begin
                  reqAddr_d = redirect ? target : pc_q;
                  state_d   = FETCH;
               end
            end
         end
         ERROR: begin
            valid_d = 1'b0;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign icache_req  = (state_q == FETCH) || (state_q == DRAIN);
   assign icache_addr = reqAddr_q & ALIGN_MASK;
   assign instr       = instr_q;
   assign instr_pc    = instrPc_q;
   assign pc_plus4    = pcPlus4_q;
   assign instr_valid = valid_q;
`ifdef MISALIGN_CHECK_EN
   assign misalign_err = (state_q == ERROR);
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit; adapts the misaligned-redirect step when MISALIGN_CHECK_EN is defined.
module tb_instr_fetch_unit;

   localparam logic [31:0] RPC = 32'h0040_0000;

   logic        clk;
   logic        rst;
   logic        icacheReq;
   logic [31:0] icacheAddr;
   logic [31:0] icacheRdata;
   logic        icacheReady;
   logic [31:0] instr;
   logic [31:0] instrPc;
   logic [31:0] pcPlus4;
   logic        instrValid;
   logic        instrReady;
   logic        redirect;
   logic [31:0] redirectPc;
`ifdef MISALIGN_CHECK_EN
   logic        misalignErr;
`endif

   int passCount = 0;
   int totalCount = 0;

   instr_fetch_unit #(
      .ADDR_WIDTH (32),
      .RESET_PC   (RPC),
      .NOP_WORD   (32'h0000_0000)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .icache_req   (icacheReq),
      .icache_addr  (icacheAddr),
      .icache_rdata (icacheRdata),
      .icache_ready (icacheReady),
      .instr        (instr),
      .instr_pc     (instrPc),
      .pc_plus4     (pcPlus4),
      .instr_valid  (instrValid),
      .instr_ready  (instrReady),
      .redirect     (redirect),
      .redirect_pc  (redirectPc)
`ifdef MISALIGN_CHECK_EN
      ,
      .misalign_err (misalignErr)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic applyStimulus(input logic rd, input logic [31:0] rpc, input logic rdy,
                                input logic [31:0] rdata, input logic ir);
      redirect    = rd;
      redirectPc  = rpc;
      icacheReady = rdy;
      icacheRdata = rdata;
      instrReady  = ir;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      totalCount++;
      assert (obs === exp) passCount++;
      else $error("[TB] FAIL %s: observed %08h expected %08h", tag, obs, exp);
   endtask

   initial begin
      rst = 1'b1;
      applyStimulus(0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0);
      rst = 1'b0;
      checkOutput("rst_req", 32'(icacheReq), 0);
      checkOutput("rst_valid", 32'(instrValid), 0);
      checkOutput("rst_instr", instr, 32'h0);
      checkOutput("rst_instr_pc", instrPc, 32'h0);
      checkOutput("rst_pc_plus4", pcPlus4, 32'h0);
`ifdef MISALIGN_CHECK_EN
      checkOutput("rst_misalign", 32'(misalignErr), 0);
`endif

      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("first_req", 32'(icacheReq), 1);
      checkOutput("first_addr", icacheAddr, 32'h0040_0000);

      applyStimulus(0, 0, 1, 32'h8C08_0004, 0);
      checkOutput("hit_instr", instr, 32'h8C08_0004);
      checkOutput("hit_instr_pc", instrPc, 32'h0040_0000);
      checkOutput("hit_pc_plus4", pcPlus4, 32'h0040_0004);
      checkOutput("hit_valid", 32'(instrValid), 1);
      checkOutput("hit_req_low", 32'(icacheReq), 0);

      applyStimulus(0, 0, 0, 0, 1);
      checkOutput("next_addr", icacheAddr, 32'h0040_0004);
      checkOutput("next_req", 32'(icacheReq), 1);
      checkOutput("next_valid", 32'(instrValid), 0);
      checkOutput("next_instr_nop", instr, 32'h0);

      for (int i = 0; i < 5; i++) begin
         applyStimulus(0, 0, 0, 32'hFFFF_FFFF, 0);
         checkOutput("miss_req", 32'(icacheReq), 1);
         checkOutput("miss_addr", icacheAddr, 32'h0040_0004);
         checkOutput("miss_valid", 32'(instrValid), 0);
      end
      applyStimulus(0, 0, 1, 32'h2108_0001, 0);
      checkOutput("miss_instr", instr, 32'h2108_0001);
      checkOutput("miss_instr_pc", instrPc, 32'h0040_0004);
      checkOutput("miss_pc_plus4", pcPlus4, 32'h0040_0008);

      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 0, 0, 0, 0);
         checkOutput("stall_instr", instr, 32'h2108_0001);
         checkOutput("stall_instr_pc", instrPc, 32'h0040_0004);
         checkOutput("stall_valid", 32'(instrValid), 1);
         checkOutput("stall_req", 32'(icacheReq), 0);
      end
      applyStimulus(0, 0, 0, 0, 1);
      checkOutput("release_addr", icacheAddr, 32'h0040_0008);

      applyStimulus(1, 32'h0040_0020, 0, 0, 0);
      checkOutput("drain_req", 32'(icacheReq), 1);
      checkOutput("drain_addr", icacheAddr, 32'h0040_0008);
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("drain_hold_addr", icacheAddr, 32'h0040_0008);
      checkOutput("drain_valid", 32'(instrValid), 0);
      applyStimulus(0, 0, 1, 32'hDEAD_BEEF, 0);
      checkOutput("drain_discard_valid", 32'(instrValid), 0);
      checkOutput("drain_discard_instr", instr, 32'h0);
      checkOutput("drain_target_addr", icacheAddr, 32'h0040_0020);
      checkOutput("drain_target_req", 32'(icacheReq), 1);

      applyStimulus(0, 0, 1, 32'hAABB_CCDD, 0);
      checkOutput("tgt_instr", instr, 32'hAABB_CCDD);
      checkOutput("tgt_instr_pc", instrPc, 32'h0040_0020);

      applyStimulus(1, 32'h0040_0040, 0, 0, 1);
      checkOutput("redir_valid", 32'(instrValid), 0);
      checkOutput("redir_addr", icacheAddr, 32'h0040_0040);

      applyStimulus(1, 32'hFFFF_FFFC, 1, 32'h1111_1111, 0);
      checkOutput("redir_hit_valid", 32'(instrValid), 0);
      checkOutput("redir_hit_addr", icacheAddr, 32'hFFFF_FFFC);
      applyStimulus(0, 0, 1, 32'h2222_2222, 0);
      checkOutput("wrap_instr", instr, 32'h2222_2222);
      checkOutput("wrap_instr_pc", instrPc, 32'hFFFF_FFFC);
      checkOutput("wrap_pc_plus4", pcPlus4, 32'h0);
      applyStimulus(0, 0, 0, 0, 1);
      checkOutput("wrap_addr", icacheAddr, 32'h0);
      applyStimulus(0, 0, 0, 0, 1);
      checkOutput("ignored_ready_addr", icacheAddr, 32'h0);
      checkOutput("ignored_ready_valid", 32'(instrValid), 0);

      applyStimulus(0, 0, 1, 32'h3333_3333, 0);
      checkOutput("pre_mis_instr", instr, 32'h3333_3333);
      applyStimulus(1, 32'h0040_0022, 0, 0, 1);
      checkOutput("mis_valid", 32'(instrValid), 0);
`ifdef MISALIGN_CHECK_EN
      checkOutput("mis_err", 32'(misalignErr), 1);
      checkOutput("mis_req", 32'(icacheReq), 0);
      applyStimulus(0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 1);
      checkOutput("mis_sticky_err", 32'(misalignErr), 1);
      checkOutput("mis_sticky_req", 32'(icacheReq), 0);
`else
      checkOutput("mis_forced_addr", icacheAddr, 32'h0040_0020);
      checkOutput("mis_req", 32'(icacheReq), 1);
`endif

      rst = 1'b1;
      applyStimulus(0, 0, 0, 0, 0);
      rst = 1'b0;
      checkOutput("rerst_req", 32'(icacheReq), 0);
      checkOutput("rerst_valid", 32'(instrValid), 0);
      checkOutput("rerst_instr_pc", instrPc, 32'h0);
`ifdef MISALIGN_CHECK_EN
      checkOutput("rerst_misalign", 32'(misalignErr), 0);
`endif
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("rerst_addr", icacheAddr, 32'h0040_0000);
      checkOutput("rerst_fetch", 32'(icacheReq), 1);

      $display("%0d/%0d checks passed", passCount, totalCount);
      $finish;
   end

endmodule
